// File: rtl/fmul_36bit_arb_pkg.sv
// fmul_36bit_arb_pkg: shared FP36 types and tag decode helper for the fmul arbiter
package fmul_36bit_arb_pkg;
  localparam int FP36_W = 36;
  localparam int MAX_REQ = 8;
  typedef logic [FP36_W-1:0] fp36_t;
  function automatic logic [MAX_REQ-1:0] onehot_dec(input logic [2:0] id);
    logic [MAX_REQ-1:0] r;
    r = '0;
    r[id] = 1'b1;
    return r;
  endfunction
endpackage

// File: rtl/fmul_36bit_arb_tag_fifo.sv
// fmul_36bit_arb_tag_fifo: in-order FIFO of requester tags for ops in flight
module fmul_36bit_arb_tag_fifo #(
  parameter int TAG_W = 2,
  parameter int DEPTH = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic [TAG_W-1:0]       tag_i,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [TAG_W-1:0]       head_o,
  output logic [$clog2(DEPTH):0] count_o
);
  localparam int AW = $clog2(DEPTH);
  logic [TAG_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, rd_q;
  logic [AW:0]      cnt_q;
  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_q] <= tag_i;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= push_i ? wr_q + 1'b1 : wr_q;
      rd_q  <= pop_i ? rd_q + 1'b1 : rd_q;
      cnt_q <= cnt_q + (AW+1)'(push_i) - (AW+1)'(pop_i);
    end
  end
  assign full_o  = cnt_q == (AW+1)'(DEPTH);
  assign empty_o = cnt_q == '0;
  assign head_o  = mem_q[rd_q];
  assign count_o = cnt_q;
endmodule

// File: rtl/fmul_36bit_arbiter.sv
// fmul_36bit_arbiter: shares one FP36 multiplier pipeline among N_REQ requesters, returning results by tag.
// Define FMUL_36BIT_ARB_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.
module fmul_36bit_arbiter
  import fmul_36bit_arb_pkg::*;
#(
  parameter int N_REQ        = 4,
  parameter int MAX_INFLIGHT = 8
) (
  input  logic                    iCLOCK,
  input  logic                    iRESET_SYNC,
  input  logic [N_REQ-1:0]        iREQ_VALID,
  output logic [N_REQ-1:0]        oREQ_BUSY,
  input  logic [N_REQ*FP36_W-1:0] iREQ_DATA_A,
  input  logic [N_REQ*FP36_W-1:0] iREQ_DATA_B,
  output logic                    oFMUL_VALID,
  input  logic                    iFMUL_BUSY,
  output fp36_t                   oFMUL_DATA_A,
  output fp36_t                   oFMUL_DATA_B,
  input  logic                    iFMUL_RES_VALID,
  output logic                    oFMUL_RES_BUSY,
  input  fp36_t                   iFMUL_RES_DATA,
  output logic [N_REQ-1:0]        oRES_VALID,
  input  logic [N_REQ-1:0]        iRES_BUSY,
  output fp36_t                   oRES_DATA,
  output logic                    oERR_ORPHAN
);
  localparam int TW = $clog2(N_REQ);
  localparam int CW = $clog2(MAX_INFLIGHT) + 1;
  logic [TW-1:0] base, gnt_id, head;
  logic          gnt_vld, stall, accept, pop, full, empty;
  logic [CW-1:0] count;
  int            idx;
  logic          valid_q, valid_d, err_q;
  fp36_t         a_q, a_d, b_q, b_d;
`ifdef FMUL_36BIT_ARB_FIXED_PRIO_EN
  assign base = '0;
`else
  logic [TW-1:0] rr_q;
  always_ff @(posedge iCLOCK) begin
    if (iRESET_SYNC) rr_q <= '0;
    else if (accept) rr_q <= gnt_id == TW'(N_REQ-1) ? '0 : gnt_id + 1'b1;
  end
  assign base = rr_q;
`endif
  // Scan downward so the requester closest to base is assigned last and wins.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_id  = '0;
    idx     = 0;
    for (int k = N_REQ-1; k >= 0; k--) begin
      idx = int'(base) + k;
      idx = idx >= N_REQ ? idx - N_REQ : idx;
      if (iREQ_VALID[idx]) begin
        gnt_vld = 1'b1;
        gnt_id  = TW'(idx);
      end
    end
  end
  assign stall  = (iFMUL_BUSY && valid_q) || full;
  assign accept = gnt_vld && !stall && !iRESET_SYNC;
  always_comb begin
    oREQ_BUSY = '1;
    for (int i = 0; i < N_REQ; i++)
      oREQ_BUSY[i] = iRESET_SYNC || stall || !(gnt_vld && gnt_id == TW'(i));
  end
  assign valid_d = accept || (iFMUL_BUSY && valid_q);
  assign a_d     = accept ? iREQ_DATA_A[FP36_W*gnt_id +: FP36_W] : a_q;
  assign b_d     = accept ? iREQ_DATA_B[FP36_W*gnt_id +: FP36_W] : b_q;
  always_ff @(posedge iCLOCK) begin
    if (iRESET_SYNC) begin
      valid_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      err_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      a_q     <= a_d;
      b_q     <= b_d;
      err_q   <= err_q || (count == '0 && iFMUL_RES_VALID);
    end
  end
  fmul_36bit_arb_tag_fifo #(.TAG_W(TW), .DEPTH(MAX_INFLIGHT)) u_tag_fifo (
    .clk_i   (iCLOCK),
    .rst_i   (iRESET_SYNC),
    .push_i  (accept),
    .pop_i   (pop),
    .tag_i   (gnt_id),
    .full_o  (full),
    .empty_o (empty),
    .head_o  (head),
    .count_o (count)
  );
  assign pop            = !empty && !iRESET_SYNC && iFMUL_RES_VALID && !iRES_BUSY[head];
  assign oRES_VALID     = (!empty && !iRESET_SYNC && iFMUL_RES_VALID) ? N_REQ'(onehot_dec(3'(head))) : '0;
  assign oFMUL_RES_BUSY = !empty && !iRESET_SYNC && iRES_BUSY[head];
  assign oRES_DATA      = iFMUL_RES_DATA;
  assign oFMUL_VALID    = valid_q;
  assign oFMUL_DATA_A   = a_q;
  assign oFMUL_DATA_B   = b_q;
  assign oERR_ORPHAN    = err_q;
endmodule
